// File: rtl/ddram_arbiter.sv
// ddram_arbiter: serialises the mcr, sdram and vram requesters onto one 64-bit DDRAM port.
// Optional macro DDRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority.
module ddram_arbiter #(
    parameter logic [28:0] MCR_BASE   = 29'h0000000,
    parameter logic [28:0] SDRAM_BASE = 29'h0100000,
    parameter logic [28:0] VRAM_BASE  = 29'h0080000
) (
    input  logic        sdram_clk,
    input  logic        reset,

    input  logic [13:0] mcr_addr,
    input  logic [48:0] mcr_data_in,
    output logic [48:0] mcr_data_out,
    input  logic        mcr_req,
    input  logic        mcr_write,
    output logic        mcr_ready,
    output logic        mcr_done,

    input  logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_in,
    output logic [31:0] sdram_data_out,
    input  logic        sdram_req,
    input  logic        sdram_write,
    output logic        sdram_ready,
    output logic        sdram_done,

    input  logic [14:0] vram_cpu_addr,
    input  logic [31:0] vram_cpu_data_in,
    output logic [31:0] vram_cpu_data_out,
    input  logic        vram_cpu_req,
    input  logic        vram_cpu_write,
    output logic        vram_cpu_ready,
    output logic        vram_cpu_done,

    input  logic        DDRAM_BUSY,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_RD,
    output logic        DDRAM_WE
);

    localparam logic [1:0] PORT_MCR   = 2'd0;
    localparam logic [1:0] PORT_SDRAM = 2'd1;
    localparam logic [1:0] PORT_VRAM  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_ACK     = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  pending;
    logic        grant_vld;
    logic [1:0]  grant_id;

    logic        cand_wr;
    logic        cand_half;
    logic [28:0] cand_addr;
    logic [63:0] cand_din;
    logic [7:0]  cand_be;

    logic [1:0]  port_q;
    logic        wr_q;
    logic        half_q;

    // Returns {found, port}: first pending port searching upward from start, wrapping at 3.
    function automatic logic [2:0] pick(input logic [2:0] pend, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 0; i < 3; i++) begin
            k = 2'((int'(start) + i) % 3);
            if (!res[2] && pend[k])
                res = {1'b1, k};
        end
        return res;
    endfunction

    function automatic logic [31:0] half_sel(input logic [63:0] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

    function automatic logic [7:0] half_be(input logic hi);
        return hi ? 8'hF0 : 8'h0F;
    endfunction

    // A write strobe counts as a pending request on its own; req alone means read.
    assign pending = {vram_cpu_req | vram_cpu_write,
                      sdram_req    | sdram_write,
                      mcr_req      | mcr_write};

`ifdef DDRAM_ARB_RR_EN
    logic [1:0] rr_ptr;

    always_comb {grant_vld, grant_id} = pick(pending, rr_ptr);

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset)
            rr_ptr <= PORT_MCR;
        else if (state == S_IDLE && grant_vld)
            rr_ptr <= (grant_id == PORT_VRAM) ? PORT_MCR : grant_id + 2'd1;
    end
`else
    always_comb {grant_vld, grant_id} = pick(pending, PORT_MCR);
`endif

    always_comb begin
        cand_wr   = mcr_write;
        cand_half = 1'b0;
        cand_addr = MCR_BASE + {15'b0, mcr_addr};
        cand_din  = {15'b0, mcr_data_in};
        cand_be   = 8'h7F;
        case (grant_id)
            PORT_SDRAM: begin
                cand_wr   = sdram_write;
                cand_half = sdram_addr[0];
                cand_addr = SDRAM_BASE + {8'b0, sdram_addr[21:1]};
                cand_din  = {sdram_data_in, sdram_data_in};
                cand_be   = half_be(sdram_addr[0]);
            end
            PORT_VRAM: begin
                cand_wr   = vram_cpu_write;
                cand_half = vram_cpu_addr[0];
                cand_addr = VRAM_BASE + {15'b0, vram_cpu_addr[14:1]};
                cand_din  = {vram_cpu_data_in, vram_cpu_data_in};
                cand_be   = half_be(vram_cpu_addr[0]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (grant_vld) state_nxt = S_ISSUE;
            S_ISSUE:   if (!DDRAM_BUSY) state_nxt = wr_q ? S_ACK : S_WAIT_RD;
            S_WAIT_RD: if (DDRAM_DOUT_READY) state_nxt = S_ACK;
            S_ACK:     state_nxt = S_HOLD;
            S_HOLD:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Command fields are captured once at grant so they stay stable through BUSY stalls.
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            port_q     <= PORT_MCR;
            wr_q       <= 1'b0;
            half_q     <= 1'b0;
            DDRAM_ADDR <= '0;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
        end else if (state == S_IDLE && grant_vld) begin
            port_q     <= grant_id;
            wr_q       <= cand_wr;
            half_q     <= cand_half;
            DDRAM_ADDR <= cand_addr;
            DDRAM_DIN  <= cand_din;
            DDRAM_BE   <= cand_be;
        end
    end

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            mcr_data_out      <= '0;
            sdram_data_out    <= '0;
            vram_cpu_data_out <= '0;
        end else if (state == S_WAIT_RD && DDRAM_DOUT_READY) begin
            case (port_q)
                PORT_MCR:   mcr_data_out      <= DDRAM_DOUT[48:0];
                PORT_SDRAM: sdram_data_out    <= half_sel(DDRAM_DOUT, half_q);
                PORT_VRAM:  vram_cpu_data_out <= half_sel(DDRAM_DOUT, half_q);
                default: ;
            endcase
        end
    end

    assign DDRAM_BURSTCNT = 8'd1;

    always_comb begin
        DDRAM_RD       = 1'b0;
        DDRAM_WE       = 1'b0;
        mcr_ready      = 1'b0;
        mcr_done       = 1'b0;
        sdram_ready    = 1'b0;
        sdram_done     = 1'b0;
        vram_cpu_ready = 1'b0;
        vram_cpu_done  = 1'b0;
        case (state)
            S_ISSUE: begin
                DDRAM_RD = !wr_q;
                DDRAM_WE = wr_q;
            end
            S_ACK: begin
                case (port_q)
                    PORT_MCR: begin
                        mcr_ready = !wr_q;
                        mcr_done  = wr_q;
                    end
                    PORT_SDRAM: begin
                        sdram_ready = !wr_q;
                        sdram_done  = wr_q;
                    end
                    PORT_VRAM: begin
                        vram_cpu_ready = !wr_q;
                        vram_cpu_done  = wr_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: directed scenarios plus randomized traffic against a port-level memory model.
`timescale 1ns/1ps
module tb_ddram_arbiter;

    localparam logic [28:0] MCR_BASE   = 29'h0000000;
    localparam logic [28:0] SDRAM_BASE = 29'h0100000;
    localparam logic [28:0] VRAM_BASE  = 29'h0080000;
`ifdef DDRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        sdram_clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] mcr_addr = '0;
    logic [48:0] mcr_data_in = '0;
    logic [48:0] mcr_data_out;
    logic        mcr_req = 1'b0, mcr_write = 1'b0, mcr_ready, mcr_done;
    logic [21:0] sdram_addr = '0;
    logic [31:0] sdram_data_in = '0;
    logic [31:0] sdram_data_out;
    logic        sdram_req = 1'b0, sdram_write = 1'b0, sdram_ready, sdram_done;
    logic [14:0] vram_cpu_addr = '0;
    logic [31:0] vram_cpu_data_in = '0;
    logic [31:0] vram_cpu_data_out;
    logic        vram_cpu_req = 1'b0, vram_cpu_write = 1'b0, vram_cpu_ready, vram_cpu_done;
    logic        DDRAM_BUSY = 1'b0;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_RD, DDRAM_WE;

    int total = 0;
    int bad = 0;
    int m_ptr = 0;
    logic [63:0] exp_dout [3];
    logic [63:0] dmem [int];
    logic [63:0] ref_mem [int];
    bit          act [3];
    bit          cur_wr [3];
    bit          cur_both [3];
    int          cur_addr [3];
    logic [63:0] cur_data [3];
    int          rem [3];
    int          grant_log [$];

    ddram_arbiter dut (
        .sdram_clk(sdram_clk), .reset(reset),
        .mcr_addr(mcr_addr), .mcr_data_in(mcr_data_in), .mcr_data_out(mcr_data_out),
        .mcr_req(mcr_req), .mcr_write(mcr_write), .mcr_ready(mcr_ready), .mcr_done(mcr_done),
        .sdram_addr(sdram_addr), .sdram_data_in(sdram_data_in), .sdram_data_out(sdram_data_out),
        .sdram_req(sdram_req), .sdram_write(sdram_write), .sdram_ready(sdram_ready), .sdram_done(sdram_done),
        .vram_cpu_addr(vram_cpu_addr), .vram_cpu_data_in(vram_cpu_data_in),
        .vram_cpu_data_out(vram_cpu_data_out), .vram_cpu_req(vram_cpu_req),
        .vram_cpu_write(vram_cpu_write), .vram_cpu_ready(vram_cpu_ready), .vram_cpu_done(vram_cpu_done),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_DIN(DDRAM_DIN),
        .DDRAM_BE(DDRAM_BE), .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE)
    );

    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    function automatic logic [28:0] exp_addr(input int p, input int a);
        case (p)
            0:       return MCR_BASE + 29'(a);
            1:       return SDRAM_BASE + 29'(a / 2);
            default: return VRAM_BASE + 29'(a / 2);
        endcase
    endfunction

    function automatic logic [7:0] exp_be(input int p, input int a);
        if (p == 0) return 8'h7F;
        return (a % 2 == 1) ? 8'hF0 : 8'h0F;
    endfunction

    function automatic logic [63:0] exp_din(input int p, input logic [63:0] d);
        if (p == 0) return {15'b0, d[48:0]};
        return {d[31:0], d[31:0]};
    endfunction

    function automatic logic [63:0] obs_dout(input int p);
        case (p)
            0:       return {15'b0, mcr_data_out};
            1:       return {32'b0, sdram_data_out};
            default: return {32'b0, vram_cpu_data_out};
        endcase
    endfunction

    function automatic int model_pick();
        int start;
        start = RR_EN ? m_ptr : 0;
        for (int i = 0; i < 3; i++)
            if (act[(start + i) % 3]) return (start + i) % 3;
        return -1;
    endfunction

    task automatic note_grant(input int p);
        m_ptr = (p + 1) % 3;
    endtask

    task automatic idle_inputs();
        mcr_req = 0; mcr_write = 0; sdram_req = 0; sdram_write = 0;
        vram_cpu_req = 0; vram_cpu_write = 0; DDRAM_BUSY = 0; DDRAM_DOUT_READY = 0;
        for (int p = 0; p < 3; p++) act[p] = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        m_ptr = 0;
        for (int p = 0; p < 3; p++) exp_dout[p] = '0;
        tick();
    endtask

    task automatic apply_inputs();
        mcr_addr         = 14'(cur_addr[0]);
        mcr_data_in      = cur_data[0][48:0];
        mcr_write        = act[0] && cur_wr[0];
        mcr_req          = act[0] && (!cur_wr[0] || cur_both[0]);
        sdram_addr       = 22'(cur_addr[1]);
        sdram_data_in    = cur_data[1][31:0];
        sdram_write      = act[1] && cur_wr[1];
        sdram_req        = act[1] && (!cur_wr[1] || cur_both[1]);
        vram_cpu_addr    = 15'(cur_addr[2]);
        vram_cpu_data_in = cur_data[2][31:0];
        vram_cpu_write   = act[2] && cur_wr[2];
        vram_cpu_req     = act[2] && (!cur_wr[2] || cur_both[2]);
    endtask

    task automatic new_txn(input int p, input bit rnd);
        act[p]      = 1;
        cur_wr[p]   = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        cur_both[p] = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
        cur_addr[p] = (p == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
        cur_data[p] = {$urandom, $urandom};
    endtask

    // Acts as requesters plus a DDR3 device; every grant is checked against the model.
    task automatic run_batch(input int n0, input int n1, input int n2, input bit rnd);
        int p, n, k, dly, key;
        logic [28:0] a0;
        logic [63:0] d0, w, rv;
        logic [7:0]  b0;
        logic [5:0]  exp_flags, obs_flags;
        rem[0] = n0; rem[1] = n1; rem[2] = n2;
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            act[i] = 0;
            if (rem[i] > 0) new_txn(i, rnd);
        end
        apply_inputs();
        while (rem[0] + rem[1] + rem[2] > 0) begin
            p = model_pick();
            n = 0;
            do begin
                tick();
                n++;
            end while (!(DDRAM_RD || DDRAM_WE) && n < 20);
            total++;
            if (!(DDRAM_RD || DDRAM_WE)) begin
                bad++;
                $display("FAIL grant_timeout: no DDRAM_RD/WE within 20 cycles, expected port %0d", p);
                do_reset();
                return;
            end
            if (DDRAM_ADDR !== exp_addr(p, cur_addr[p]) || DDRAM_BE !== exp_be(p, cur_addr[p]) ||
                DDRAM_WE !== cur_wr[p] || DDRAM_RD !== !cur_wr[p] ||
                (cur_wr[p] && DDRAM_DIN !== exp_din(p, cur_data[p]))) begin
                bad++;
                $display("FAIL grant: got addr=%h be=%h we=%b rd=%b din=%h, want port %0d addr=%h be=%h we=%b din=%h",
                         DDRAM_ADDR, DDRAM_BE, DDRAM_WE, DDRAM_RD, DDRAM_DIN, p,
                         exp_addr(p, cur_addr[p]), exp_be(p, cur_addr[p]), cur_wr[p],
                         exp_din(p, cur_data[p]));
            end
            grant_log.push_back(p);
            note_grant(p);
            a0 = DDRAM_ADDR; d0 = DDRAM_DIN; b0 = DDRAM_BE;
            k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) begin
                DDRAM_BUSY = 1;
                tick();
                total++;
                if (DDRAM_ADDR !== a0 || DDRAM_DIN !== d0 || DDRAM_BE !== b0 ||
                    DDRAM_WE !== cur_wr[p] || DDRAM_RD !== !cur_wr[p]) begin
                    bad++;
                    $display("FAIL busy_stable: addr=%h din=%h be=%h we=%b rd=%b, want addr=%h din=%h be=%h",
                             DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD, a0, d0, b0);
                end
            end
            DDRAM_BUSY = 0;
            tick();
            key = p * (1 << 24) + cur_addr[p];
            if (cur_wr[p]) begin
                w = dmem.exists(int'(a0)) ? dmem[int'(a0)] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (b0[b]) w[8*b +: 8] = d0[8*b +: 8];
                dmem[int'(a0)] = w;
                ref_mem[key] = (p == 0) ? {15'b0, cur_data[p][48:0]} : {32'b0, cur_data[p][31:0]};
            end else begin
                dly = int'($urandom_range(0, 3));
                for (int i = 0; i < dly; i++) begin
                    DDRAM_DOUT = {$urandom, $urandom};
                    tick();
                end
                DDRAM_DOUT = dmem.exists(int'(a0)) ? dmem[int'(a0)] : 64'h0;
                DDRAM_DOUT_READY = 1;
                tick();
                DDRAM_DOUT_READY = 0;
                DDRAM_DOUT = {$urandom, $urandom};
                rv = ref_mem.exists(key) ? ref_mem[key] : 64'h0;
                exp_dout[p] = rv;
            end
            exp_flags = '0;
            exp_flags[2 * p + (cur_wr[p] ? 1 : 0)] = 1'b1;
            obs_flags = {vram_cpu_done, vram_cpu_ready, sdram_done, sdram_ready, mcr_done, mcr_ready};
            total++;
            if (obs_flags !== exp_flags) begin
                bad++;
                $display("FAIL ack_flags: got %b want %b (port %0d)", obs_flags, exp_flags, p);
            end
            total++;
            if (obs_dout(0) !== exp_dout[0] || obs_dout(1) !== exp_dout[1] || obs_dout(2) !== exp_dout[2]) begin
                bad++;
                $display("FAIL data_out: got mcr=%h sdram=%h vram=%h want mcr=%h sdram=%h vram=%h",
                         obs_dout(0), obs_dout(1), obs_dout(2), exp_dout[0], exp_dout[1], exp_dout[2]);
            end
            act[p] = 0;
            rem[p]--;
            apply_inputs();
            tick();
            total++;
            obs_flags = {vram_cpu_done, vram_cpu_ready, sdram_done, sdram_ready, mcr_done, mcr_ready};
            if (obs_flags !== 6'b0 || DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin
                bad++;
                $display("FAIL hold_quiet: flags=%b rd=%b we=%b, want all 0", obs_flags, DDRAM_RD, DDRAM_WE);
            end
            if (rem[p] > 0) new_txn(p, rnd);
            apply_inputs();
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        total++;
        if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0 || DDRAM_ADDR !== 29'h0 || DDRAM_DIN !== 64'h0 ||
            DDRAM_BE !== 8'h0 || DDRAM_BURSTCNT !== 8'd1) begin
            bad++;
            $display("FAIL reset_ddram: rd=%b we=%b addr=%h din=%h be=%h burst=%h, want 0/0/0/0/0/01",
                     DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT);
        end
        total++;
        if ({mcr_ready, mcr_done, sdram_ready, sdram_done, vram_cpu_ready, vram_cpu_done} !== 6'b0 ||
            mcr_data_out !== 49'h0 || sdram_data_out !== 32'h0 || vram_cpu_data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_ports: flags/data_out not zero (mcr=%h sdram=%h vram=%h)",
                     mcr_data_out, sdram_data_out, vram_cpu_data_out);
        end
        reset = 0;
        m_ptr = 0;
        for (int p = 0; p < 3; p++) exp_dout[p] = '0;
        tick();
    endtask

    task automatic test_sdram_write();
        logic [31:0] d;
        d = 32'o10101111;
        sdram_addr = 22'd1; sdram_data_in = d; sdram_write = 1;
        tick();
        total++;
        if (DDRAM_WE !== 1'b1 || DDRAM_RD !== 1'b0 || DDRAM_ADDR !== SDRAM_BASE ||
            DDRAM_BE !== 8'hF0 || DDRAM_DIN !== {d, d} || sdram_done !== 1'b0) begin
            bad++;
            $display("FAIL sdram_write_issue: we=%b rd=%b addr=%h be=%h din=%h, want 1/0/%h/f0/%h",
                     DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN, SDRAM_BASE, {d, d});
        end
        tick();
        total++;
        if (sdram_done !== 1'b1 || DDRAM_WE !== 1'b0 || sdram_ready !== 1'b0) begin
            bad++;
            $display("FAIL sdram_write_done: done=%b we=%b ready=%b, want 1/0/0", sdram_done, DDRAM_WE, sdram_ready);
        end
        sdram_write = 0;
        tick();
        total++;
        if (sdram_done !== 1'b0) begin
            bad++;
            $display("FAIL sdram_done_pulse: done=%b one cycle later, want 0", sdram_done);
        end
        note_grant(1);
        tick();
    endtask

    task automatic test_sdram_read();
        int early;
        early = 0;
        sdram_addr = 22'd1; sdram_req = 1;
        tick();
        total++;
        if (DDRAM_RD !== 1'b1 || DDRAM_WE !== 1'b0 || DDRAM_ADDR !== SDRAM_BASE || DDRAM_BE !== 8'hF0) begin
            bad++;
            $display("FAIL sdram_read_issue: rd=%b we=%b addr=%h be=%h, want 1/0/%h/f0",
                     DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_BE, SDRAM_BASE);
        end
        DDRAM_DOUT = 64'hAAAA5555_12345678;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sdram_ready !== 1'b0 || DDRAM_RD !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL sdram_read_wait: %0d cycles with ready/rd set while waiting, want 0", early);
        end
        DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        DDRAM_DOUT = 64'hDEADBEEF_CAFEF00D;
        total++;
        if (sdram_ready !== 1'b1 || sdram_data_out !== 32'hAAAA5555 || sdram_done !== 1'b0) begin
            bad++;
            $display("FAIL sdram_read_data: ready=%b done=%b data=%h, want 1/0/aaaa5555",
                     sdram_ready, sdram_done, sdram_data_out);
        end
        sdram_req = 0;
        exp_dout[1] = 64'h0000_0000_AAAA5555;
        tick();
        total++;
        if (sdram_ready !== 1'b0 || sdram_data_out !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL sdram_read_hold: ready=%b data=%h, want 0/aaaa5555", sdram_ready, sdram_data_out);
        end
        note_grant(1);
        tick();
    endtask

    task automatic test_mcr_write_busy();
        logic [48:0] d;
        int good, dones;
        d = 49'o222200002222;
        good = 0;
        dones = 0;
        DDRAM_BUSY = 1;
        mcr_addr = 14'd3; mcr_data_in = d; mcr_write = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) DDRAM_BUSY = 0;
            if (DDRAM_WE === 1'b1 && DDRAM_ADDR === MCR_BASE + 29'd3 && DDRAM_DIN === {15'b0, d} &&
                DDRAM_BE === 8'h7F && DDRAM_BURSTCNT === 8'd1 && mcr_done === 1'b0) good++;
            tick();
        end
        total++;
        if (good != 6) begin
            bad++;
            $display("FAIL mcr_busy_stable: %0d of 6 cycles with stable WE/ADDR/DIN/BE, want 6", good);
        end
        for (int i = 0; i < 4; i++) begin
            if (mcr_done === 1'b1) dones++;
            if (i == 0) begin
                total++;
                if (mcr_done !== 1'b1 || DDRAM_WE !== 1'b0) begin
                    bad++;
                    $display("FAIL mcr_done: done=%b we=%b after busy released, want 1/0", mcr_done, DDRAM_WE);
                end
                mcr_write = 0;
            end
            tick();
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL mcr_single_done: %0d done pulses, want 1", dones);
        end
        note_grant(0);
    endtask

    task automatic test_vram_both();
        logic [31:0] d;
        d = $urandom;
        vram_cpu_addr = 15'd5; vram_cpu_data_in = d; vram_cpu_req = 1; vram_cpu_write = 1;
        tick();
        total++;
        if (DDRAM_WE !== 1'b1 || DDRAM_RD !== 1'b0 || DDRAM_ADDR !== VRAM_BASE + 29'd2 ||
            DDRAM_BE !== 8'hF0 || DDRAM_DIN !== {d, d}) begin
            bad++;
            $display("FAIL vram_both_issue: we=%b rd=%b addr=%h be=%h din=%h, want 1/0/%h/f0/%h",
                     DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN, VRAM_BASE + 29'd2, {d, d});
        end
        tick();
        total++;
        if (vram_cpu_done !== 1'b1 || vram_cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL vram_both_ack: done=%b ready=%b, want 1/0", vram_cpu_done, vram_cpu_ready);
        end
        vram_cpu_req = 0; vram_cpu_write = 0;
        tick();
        total++;
        if (vram_cpu_done !== 1'b0 || vram_cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL vram_both_after: done=%b ready=%b, want 0/0", vram_cpu_done, vram_cpu_ready);
        end
        note_grant(2);
        tick();
    endtask

    task automatic test_priority();
        int first;
        first = RR_EN ? m_ptr : 0;
        run_batch(1, 1, 1, 1'b0);
        total++;
        if (grant_log.size() != 3 || grant_log[0] != first || grant_log[1] != (first + 1) % 3 ||
            grant_log[2] != (first + 2) % 3) begin
            bad++;
            $display("FAIL priority_order: got %p, want order starting at port %0d", grant_log, first);
        end
    endtask

    task automatic test_starvation();
        int pos, max_pos;
        pos = -1;
        max_pos = RR_EN ? 2 : 4;
        run_batch(4, 0, 1, 1'b0);
        foreach (grant_log[i]) if (grant_log[i] == 2 && pos < 0) pos = i;
        total++;
        if (pos < 0 || pos > max_pos) begin
            bad++;
            $display("FAIL vram_service: vram grant index %0d, want 0..%0d (log %p)", pos, max_pos, grant_log);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            run_batch(int'($urandom_range(3, 8)), int'($urandom_range(3, 8)), int'($urandom_range(3, 8)), 1'b1);
    endtask

    task automatic test_reset_mid_read();
        int late;
        late = 0;
        mcr_addr = 14'd2; mcr_req = 1;
        tick();
        tick();
        #2;
        reset = 1;
        #1;
        total++;
        if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0 || DDRAM_ADDR !== 29'h0 || DDRAM_DIN !== 64'h0 ||
            DDRAM_BE !== 8'h0 || DDRAM_BURSTCNT !== 8'd1) begin
            bad++;
            $display("FAIL midreset_ddram: rd=%b we=%b addr=%h din=%h be=%h burst=%h, want reset values",
                     DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT);
        end
        total++;
        if ({mcr_ready, mcr_done, sdram_ready, sdram_done, vram_cpu_ready, vram_cpu_done} !== 6'b0 ||
            mcr_data_out !== 49'h0 || sdram_data_out !== 32'h0 || vram_cpu_data_out !== 32'h0) begin
            bad++;
            $display("FAIL midreset_ports: mcr=%h sdram=%h vram=%h, want zero with no flags",
                     mcr_data_out, sdram_data_out, vram_cpu_data_out);
        end
        mcr_req = 0;
        @(posedge sdram_clk);
        #1;
        reset = 0;
        m_ptr = 0;
        for (int p = 0; p < 3; p++) exp_dout[p] = '0;
        DDRAM_DOUT = 64'h1234_5678_9ABC_DEF0;
        DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        for (int i = 0; i < 4; i++) begin
            if ({mcr_ready, sdram_ready, vram_cpu_ready} !== 3'b0 || DDRAM_RD !== 1'b0 ||
                DDRAM_WE !== 1'b0 || mcr_data_out !== 49'h0) late++;
            tick();
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL midreset_stray_ready: %0d cycles with ready/rd/we/data after reset, want 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_sdram_write();
        test_sdram_read();
        test_mcr_write_busy();
        test_vram_both();
        test_priority();
        test_starvation();
        test_random();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
